// File: rtl/vc_wrr_arbiter.sv
// rtl/vc_wrr_arbiter.sv - weighted round-robin arbiter draining 4 VC source FIFOs into one destination FIFO
//
// Purpose: picks one virtual channel per cycle to move a word from its source
// FIFO to the shared destination FIFO. Each VC may take up to weight[n]
// consecutive grants before the pointer rotates to the next non-empty VC.
//
// Ports:
//   clk             - clock, rising edge
//   rst             - asynchronous active-low reset
//   enb             - block enable; 0 freezes all state and blocks grants
//   init            - load weight_cfg into the weight registers (via INIT)
//   weight_cfg      - packed per-VC weights, VCn at [n*WEIGHT_W +: WEIGHT_W]
//   vc_empty        - per-VC source FIFO empty flags
//   dst_almost_full - destination backpressure, blocks grants
//   vc_pop          - one-hot pop to the granted source FIFO
//   dst_push        - push to the destination FIFO
//   vc_sel          - granted VC index this cycle, else last granted index
//   idle / active   - state indicators
module vc_wrr_arbiter #(
  parameter int WEIGHT_W = 2,
  parameter int NUM_VC   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic                         init,
  input  logic [NUM_VC*WEIGHT_W-1:0]   weight_cfg,
  input  logic [NUM_VC-1:0]            vc_empty,
  input  logic                         dst_almost_full,
  output logic [NUM_VC-1:0]            vc_pop,
  output logic                         dst_push,
  output logic [1:0]                   vc_sel,
  output logic                         idle,
  output logic                         active
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t              state_q;
  logic [1:0]          ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [WEIGHT_W-1:0] weight_q [NUM_VC];
  logic [1:0]          sel_q;

  logic                any_req;
  logic                grant;
  logic [1:0]          tgt;
  logic [1:0]          scan_idx;

  // A configured weight of 0 would starve the VC; it is promoted to 1.
  function automatic logic [WEIGHT_W-1:0] fix_w(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  assign any_req = ~&vc_empty;

  // rst is folded in so pops drop the instant reset asserts, even before the
  // state register's async clear has propagated.
  assign grant = rst && enb && !init && (state_q == ST_ACTIVE) &&
                 !dst_almost_full && any_req;

  // Target search: scan ptr+4 (== ptr) down to ptr+1 so the nearest non-empty
  // VC after ptr wins. Offset 4 only matters when ptr is the sole non-empty VC
  // with exhausted credit; it is then re-granted with a fresh credit load.
  always_comb begin
    tgt      = ptr_q;
    scan_idx = ptr_q;
    for (int k = NUM_VC; k >= 1; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (!vc_empty[scan_idx]) tgt = scan_idx;
    end
    if (!vc_empty[ptr_q] && (credit_q != '0)) tgt = ptr_q;
  end

  assign vc_pop   = grant ? (NUM_VC'(1) << tgt) : '0;
  assign dst_push = grant;
  assign vc_sel   = grant ? tgt : sel_q;
  assign idle     = (state_q == ST_IDLE);
  assign active   = (state_q == ST_ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RESET;
      ptr_q    <= '0;
      credit_q <= '0;
      sel_q    <= '0;
      for (int i = 0; i < NUM_VC; i++) weight_q[i] <= WEIGHT_W'(1);
    end else if (enb) begin
      if (grant) begin
        sel_q <= tgt;
        if ((tgt == ptr_q) && (credit_q != '0)) begin
          credit_q <= credit_q - WEIGHT_W'(1);
        end else begin
          // The grant just issued consumes one unit of the new VC's weight.
          ptr_q    <= tgt;
          credit_q <= weight_q[tgt] - WEIGHT_W'(1);
        end
      end

      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          for (int i = 0; i < NUM_VC; i++)
            weight_q[i] <= fix_w(weight_cfg[i*WEIGHT_W +: WEIGHT_W]);
          ptr_q    <= '0;
          credit_q <= fix_w(weight_cfg[0 +: WEIGHT_W]);
          state_q  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)                             state_q <= ST_INIT;
          else if (any_req && !dst_almost_full) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)          state_q <= ST_INIT;
          else if (!any_req) state_q <= ST_IDLE;
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// tb/tb_vc_wrr_arbiter.sv - directed self-checking bench for vc_wrr_arbiter
module tb_vc_wrr_arbiter;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       init;
  logic [7:0] weight_cfg;
  logic [3:0] vc_empty;
  logic       dst_almost_full;
  logic [3:0] vc_pop;
  logic       dst_push;
  logic [1:0] vc_sel;
  logic       idle;
  logic       active;

  int checks;
  int errors;

  vc_wrr_arbiter #(.WEIGHT_W(2), .NUM_VC(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .enb             (enb),
    .init            (init),
    .weight_cfg      (weight_cfg),
    .vc_empty        (vc_empty),
    .dst_almost_full (dst_almost_full),
    .vc_pop          (vc_pop),
    .dst_push        (dst_push),
    .vc_sel          (vc_sel),
    .idle            (idle),
    .active          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Resets the DUT and returns at the negedge of the first ACTIVE cycle.
  task automatic do_reset(input logic [7:0] cfg, input logic [3:0] empt);
    @(negedge clk);
    rst = 1'b0; enb = 1'b1; init = 1'b0;
    weight_cfg = cfg; vc_empty = empt; dst_almost_full = 1'b0;
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; enb = 1'b1; init = 1'b0;
    weight_cfg = 8'h00; vc_empty = 4'b0000; dst_almost_full = 1'b0;
    #1;
    checks++;
    if ({vc_pop, dst_push, vc_sel, idle, active} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pop=%b push=%b sel=%0d idle=%b active=%b, want all 0",
               vc_pop, dst_push, vc_sel, idle, active);
    end
    @(posedge clk); #1;
    checks++;
    if ({idle, active, dst_push} !== 3'b000) begin
      errors++;
      $display("FAIL reset_held: got idle=%b active=%b push=%b, want 0 0 0", idle, active, dst_push);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({idle, active, dst_push} !== 3'b000) begin
      errors++;
      $display("FAIL init_state: got idle=%b active=%b push=%b, want 0 0 0", idle, active, dst_push);
    end
    @(posedge clk); #1;
    checks++;
    if ({idle, active, dst_push} !== 3'b100) begin
      errors++;
      $display("FAIL idle_state: got idle=%b active=%b push=%b, want 1 0 0", idle, active, dst_push);
    end
    @(posedge clk); #1;
    checks++;
    if ({idle, active, dst_push, vc_sel, vc_pop} !== {3'b011, 2'd0, 4'b0001}) begin
      errors++;
      $display("FAIL first_grant: got idle=%b active=%b push=%b sel=%0d pop=%b, want 0 1 1 0 0001",
               idle, active, dst_push, vc_sel, vc_pop);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [3:0] exp_pop;
    do_reset(8'h00, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      exp_pop = 4'b0001 << exp_seq[i];
      checks++;
      if (dst_push !== 1'b1 || vc_sel !== 2'(exp_seq[i]) || vc_pop !== exp_pop) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got push=%b sel=%0d pop=%b, want 1 %0d %b",
                 i, dst_push, vc_sel, vc_pop, exp_seq[i], exp_pop);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_weighted();
    int exp_seq [14] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
    logic [3:0] exp_pop;
    do_reset(8'b01_10_01_11, 4'b0000);
    for (int i = 0; i < 14; i++) begin
      exp_pop = 4'b0001 << exp_seq[i];
      checks++;
      if (dst_push !== 1'b1 || vc_sel !== 2'(exp_seq[i]) || vc_pop !== exp_pop) begin
        errors++;
        $display("FAIL wrr_seq[%0d]: got push=%b sel=%0d pop=%b, want 1 %0d %b",
                 i, dst_push, vc_sel, vc_pop, exp_seq[i], exp_pop);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_vc();
    do_reset(8'h00, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dst_push !== 1'b1 || vc_sel !== 2'd2 || vc_pop !== 4'b0100) begin
        errors++;
        $display("FAIL single_vc[%0d]: got push=%b sel=%0d pop=%b, want 1 2 0100",
                 i, dst_push, vc_sel, vc_pop);
      end
      @(negedge clk);
    end
    vc_empty = 4'b1111;
    #1;
    checks++;
    if (vc_pop !== 4'b0000 || dst_push !== 1'b0) begin
      errors++;
      $display("FAIL empty_rise: got pop=%b push=%b, want 0000 0", vc_pop, dst_push);
    end
    @(posedge clk); #1;
    checks++;
    if ({idle, active, vc_sel} !== {2'b10, 2'd2}) begin
      errors++;
      $display("FAIL all_empty_idle: got idle=%b active=%b sel=%0d, want 1 0 2", idle, active, vc_sel);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int exp_seq [11] = '{0, 0, -1, -1, -1, 0, 1, 2, 2, 3, 0};
    do_reset(8'b01_10_01_11, 4'b0000);
    for (int i = 0; i < 11; i++) begin
      dst_almost_full = (i >= 2 && i < 5);
      #1;
      checks++;
      if (exp_seq[i] < 0) begin
        if (dst_push !== 1'b0 || vc_pop !== 4'b0000 || active !== 1'b1 || vc_sel !== 2'd0) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got push=%b pop=%b active=%b sel=%0d, want 0 0000 1 0",
                   i, dst_push, vc_pop, active, vc_sel);
        end
      end else if (dst_push !== 1'b1 || vc_sel !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL bp_seq[%0d]: got push=%b sel=%0d, want 1 %0d", i, dst_push, vc_sel, exp_seq[i]);
      end
      @(negedge clk);
    end
    dst_almost_full = 1'b0;
  endtask

  task automatic test_enable();
    int exp_seq [6] = '{0, 1, -1, -1, 2, 3};
    do_reset(8'h00, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      enb = !(i == 2 || i == 3);
      #1;
      checks++;
      if (exp_seq[i] < 0) begin
        if (dst_push !== 1'b0 || vc_pop !== 4'b0000 || vc_sel !== 2'd1 || active !== 1'b1) begin
          errors++;
          $display("FAIL enb_freeze[%0d]: got push=%b pop=%b sel=%0d active=%b, want 0 0000 1 1",
                   i, dst_push, vc_pop, vc_sel, active);
        end
      end else if (dst_push !== 1'b1 || vc_sel !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL enb_seq[%0d]: got push=%b sel=%0d, want 1 %0d", i, dst_push, vc_sel, exp_seq[i]);
      end
      @(negedge clk);
    end
    enb = 1'b1;
  endtask

  task automatic test_async_reset();
    int exp_seq [4] = '{0, 0, 0, 1};
    do_reset(8'h00, 4'b0000);
    @(negedge clk);
    weight_cfg = 8'b01_10_01_11;
    #1;
    checks++;
    if (dst_push !== 1'b1 || vc_sel !== 2'd1) begin
      errors++;
      $display("FAIL pre_rst_grant: got push=%b sel=%0d, want 1 1", dst_push, vc_sel);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({vc_pop, dst_push, vc_sel, idle, active} !== 9'b0) begin
      errors++;
      $display("FAIL async_drop: got pop=%b push=%b sel=%0d idle=%b active=%b, want all 0",
               vc_pop, dst_push, vc_sel, idle, active);
    end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({idle, active, dst_push} !== 3'b000) begin
      errors++;
      $display("FAIL rst_init: got idle=%b active=%b push=%b, want 0 0 0", idle, active, dst_push);
    end
    @(posedge clk); #1;
    checks++;
    if ({idle, active} !== 2'b10) begin
      errors++;
      $display("FAIL rst_idle: got idle=%b active=%b, want 1 0", idle, active);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) @(negedge clk);
      checks++;
      if (dst_push !== 1'b1 || vc_sel !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL reload_seq[%0d]: got push=%b sel=%0d, want 1 %0d", i, dst_push, vc_sel, exp_seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_init_reload();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset(8'b01_10_01_11, 4'b0000);
    repeat (4) @(negedge clk);
    init = 1'b1;
    weight_cfg = 8'h00;
    #1;
    checks++;
    if (dst_push !== 1'b0 || vc_pop !== 4'b0000 || active !== 1'b1) begin
      errors++;
      $display("FAIL init_no_grant: got push=%b pop=%b active=%b, want 0 0000 1", dst_push, vc_pop, active);
    end
    @(negedge clk);
    init = 1'b0;
    #1;
    checks++;
    if ({idle, active, dst_push} !== 3'b000) begin
      errors++;
      $display("FAIL init_cycle: got idle=%b active=%b push=%b, want 0 0 0", idle, active, dst_push);
    end
    @(negedge clk);
    checks++;
    if ({idle, active, dst_push} !== 3'b100) begin
      errors++;
      $display("FAIL init_to_idle: got idle=%b active=%b push=%b, want 1 0 0", idle, active, dst_push);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dst_push !== 1'b1 || vc_sel !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL init_rr[%0d]: got push=%b sel=%0d, want 1 %0d", i, dst_push, vc_sel, exp_seq[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; enb = 1'b0; init = 1'b0;
    weight_cfg = 8'h00; vc_empty = 4'b1111; dst_almost_full = 1'b0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_single_vc();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_init_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_wrr_arbiter.md
VC_WRR_ARBITER -- requirements
Module: vc_wrr_arbiter

Interface
REQ-001 SHALL have parameter WEIGHT_W, default 2, giving the per-VC weight width in bits.
REQ-002 SHALL have parameter NUM_VC, default 4, giving the number of virtual channels; only 4 is supported.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enb, input, 1 bit: block enable; 0 freezes all state and forces all grants low.
REQ-006 SHALL have port init, input, 1 bit: configuration load request, sampled on clk.
REQ-007 SHALL have port weight_cfg, input, NUM_VC*WEIGHT_W bits: per-VC weights; VCn uses bits [2n+1:2n].
REQ-008 SHALL have port vc_empty, input, NUM_VC bits: per-VC source FIFO empty flags.
REQ-009 SHALL have port dst_almost_full, input, 1 bit: destination FIFO backpressure.
REQ-010 SHALL have port vc_pop, output, NUM_VC bits: one-hot pop to the granted source FIFO.
REQ-011 SHALL have port dst_push, output, 1 bit: push to the destination FIFO.
REQ-012 SHALL have port vc_sel, output, 2 bits: index of the VC granted this cycle; holds the last granted index otherwise.
REQ-013 SHALL have port idle, output, 1 bit: high in state IDLE.
REQ-014 SHALL have port active, output, 1 bit: high in state ACTIVE.

Function
REQ-015 SHALL implement the states RESET, INIT, IDLE and ACTIVE, held in a state register.
REQ-016 In RESET, SHALL move to INIT on the first clk edge with enb=1.
REQ-017 In INIT (one cycle), SHALL capture weight_cfg into internal weight registers, treating a weight of 0 as 1, SHALL set ptr=0 and credit=weight[0], then SHALL go to IDLE.
REQ-018 In IDLE, SHALL go to ACTIVE on the next edge when any vc_empty bit is 0 and dst_almost_full=0.
REQ-019 A grant SHALL occur only when all of the following hold: state=ACTIVE, enb=1, dst_almost_full=0, and at least one VC is non-empty.
REQ-020 On a grant, vc_pop, dst_push and vc_sel SHALL be combinational (same cycle, zero latency) from the registered ptr/credit and the current inputs.
REQ-021 On a grant, dst_push SHALL be 1 and vc_pop SHALL be one-hot.
REQ-022 Outside a grant, vc_pop and dst_push SHALL be 0.
REQ-023 Grant target: if VC[ptr] is non-empty and credit>0, the target SHALL be ptr; otherwise the target SHALL be the first non-empty VC searching ptr+1, ptr+2, ptr+3 modulo 4.
REQ-024 After each grant to target t: if t==ptr, credit SHALL decrement; if t!=ptr, ptr SHALL become t and credit SHALL become weight[t]-1.
REQ-025 When credit reaches 0, the next grant SHALL search from ptr+1, giving round-robin rotation with wrap 3->0.
REQ-026 vc_pop SHALL never be asserted for a VC whose vc_empty=1, including in the same cycle that vc_empty rises.
REQ-027 When dst_almost_full=1 in ACTIVE, SHALL issue no grant, keep the state ACTIVE, and hold ptr and credit.
REQ-028 When all VCs are empty in ACTIVE, SHALL go to IDLE, keeping ptr and credit.
REQ-029 init=1 with enb=1 in IDLE or ACTIVE SHALL take priority over all other transitions: next state INIT, with no grant in that cycle.
REQ-030 enb=0 in any state SHALL hold state, ptr, credit and vc_sel, and SHALL force vc_pop=0 and dst_push=0.
REQ-031 Credit SHALL be a WEIGHT_W-bit counter, never underflow, and its maximum consecutive grants per VC SHALL be 2^WEIGHT_W-1.

Reset
REQ-032 rst=0 SHALL asynchronously force: state=RESET, ptr=0, credit=0, weights=1, vc_sel=0, vc_pop=0, dst_push=0, idle=0, active=0.
REQ-033 rst=0 asserted mid-grant SHALL drop vc_pop and dst_push in the same cycle, without waiting for a clk edge.
REQ-034 Release of rst SHALL take effect synchronously; the first possible grant SHALL come no earlier than 3 edges after release (RESET->INIT->IDLE->ACTIVE).

Verification
REQ-035 Weights 1,1,1,1, all VCs non-empty, no backpressure -> vc_sel sequence 0,1,2,3,0,... with one grant per cycle.
REQ-036 Weights 3,1,2,1 (weight_cfg=8'b01_10_01_11), all VCs non-empty -> vc_sel sequence 0,0,0,1,2,2,3, then repeats.
REQ-037 Only VC2 non-empty, ptr=0 -> grant to VC2 in the first ACTIVE cycle; VC0/VC1 never popped.
REQ-038 dst_almost_full pulsed high for 3 cycles mid-burst -> no push for exactly those 3 cycles; the grant order resumes unchanged.
REQ-039 rst low for 1 ns mid-grant -> vc_pop=0 immediately; after release, RESET then INIT then IDLE, with weights reloaded from weight_cfg.
REQ-040 init pulsed while ACTIVE, with weight_cfg changed to all 0 -> one INIT cycle with no grant, then pure round robin (weight 1) starting at VC0.
